i_mem_fill_rsp: RTL and testbench

- Instruction-memory responder on the fill side of the IFU cache-miss interface.
- Accepts one line-fill request at a time from the i_cache and reads four 32-bit words from an internal word-wide instruction memory, one word per cycle, after a programmable access latency.
- Assembles the four words into a 128-bit cache line and returns it with a one-cycle valid pulse.
- Also provides a write port for program preload by the testbench or loader.

---
 rtl/i_mem_fill_rsp.sv | 186 ++++++++++++++++++
 tb/tb_i_mem_fill_rsp.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_mem_fill_rsp.sv
// ---------------------------------------------------------------------------
// i_mem_fill_rsp
//
// Instruction-memory responder for the fill side of the IFU cache-miss path.
// It takes one line-fill request at a time and waits READ_LATENCY cycles.
// It then reads the four 32-bit words of the requested line from a word-wide
// internal memory, one word per cycle. The assembled 128-bit line is returned
// with a single-cycle rsp_valid strobe. A separate write port lets a loader or
// testbench preload the program image.
//
// Parameters:
//   MEM_DEPTH     memory depth in 32-bit words (power of two, >= 4)
//   READ_LATENCY  wait cycles before the first word read (0..15)
//
// Ports:
//   clk                           clock
//   rst                           synchronous active-high reset
//   fill_requested_address_valid  fill request strobe from the i_cache
//   fill_requested_address        requested PC, any byte within the line
//   rsp_valid                     one-cycle line-return strobe
//   rsp_address                   line-aligned address of the returned line
//   rsp_filled_instruction        returned line, word k in bits [32k+31:32k]
//   busy                          high whenever the responder is not idle
//   drop_err                      sticky: a request arrived while busy
//   wr_en / wr_addr / wr_data     preload write port (byte address, [1:0] ignored)
// ---------------------------------------------------------------------------
module i_mem_fill_rsp #(
  parameter int MEM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fill_requested_address_valid,
  input  logic [31:0]  fill_requested_address,
  output logic         rsp_valid,
  output logic [31:0]  rsp_address,
  output logic [127:0] rsp_filled_instruction,
  output logic         busy,
  output logic         drop_err,
  input  logic         wr_en,
  input  logic [31:0]  wr_addr,
  input  logic [31:0]  wr_data
);

  localparam int         AW  = $clog2(MEM_DEPTH);
  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_RESP
  } state_t;

  state_t        state;
  state_t        next_state;

  logic [31:0]   mem [MEM_DEPTH];

  logic [31:0]   base_addr;
  logic [3:0]    lat_cnt;
  logic [1:0]    beat;
  logic [95:0]   line_buf;

  logic [AW-1:0] read_idx;
  logic [AW-1:0] wr_idx;
  logic [31:0]   rd_word;

  // Address bits outside the word index are ignored by design; they are
  // gathered here so it is explicit that dropping them is intentional.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[31:AW+2], wr_addr[1:0],
                              fill_requested_address[3:0]};

  // The latched base is line aligned, so its two low word-index bits are
  // zero and the beat number can simply be OR-ed in. This keeps the four
  // reads inside the same line, and higher address bits alias modulo the
  // memory size.
  assign read_idx = base_addr[AW+1:2] | AW'(beat);
  assign wr_idx   = wr_addr[AW+1:2];
  assign rd_word  = mem[read_idx];

  assign busy = (state != ST_IDLE);

  // State register. Reset aborts any in-flight fill without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. With zero latency the WAIT state is skipped entirely.
  // WAIT leaves on the edge where the counter is at 1, which gives exactly
  // READ_LATENCY edges in WAIT.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (fill_requested_address_valid) begin
          next_state = (LAT == 4'd0) ? ST_READ : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt <= 4'd1) begin
          next_state = ST_READ;
        end
      end
      ST_READ: begin
        if (beat == 2'd3) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Preload write port. Memory contents survive reset. The read above is
  // combinational from the array, and this write only lands after the edge.
  // A READ beat that hits the word being written on the same edge therefore
  // returns the old value.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Fill datapath: latch the line base on accept and count down the access
  // latency. Collect words 0..2 into the line buffer. On the final beat,
  // publish the whole line together with the one-cycle response strobe.
  // The response address/data hold until the next response. Any request
  // seen outside IDLE is dropped and flagged until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr              <= '0;
      lat_cnt                <= '0;
      beat                   <= '0;
      line_buf               <= '0;
      rsp_valid              <= 1'b0;
      rsp_address            <= '0;
      rsp_filled_instruction <= '0;
      drop_err               <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      if (fill_requested_address_valid && (state != ST_IDLE)) begin
        drop_err <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (fill_requested_address_valid) begin
            base_addr <= {fill_requested_address[31:4], 4'b0000};
            beat      <= 2'd0;
            lat_cnt   <= LAT;
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
        end
        ST_READ: begin
          beat <= beat + 2'd1;
          case (beat)
            2'd0: line_buf[31:0]  <= rd_word;
            2'd1: line_buf[63:32] <= rd_word;
            2'd2: line_buf[95:64] <= rd_word;
            default: begin
              rsp_valid              <= 1'b1;
              rsp_address            <= base_addr;
              rsp_filled_instruction <= {rd_word, line_buf};
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_mem_fill_rsp.sv
// ---------------------------------------------------------------------------
// tb_i_mem_fill_rsp
//
// Directed bench for i_mem_fill_rsp. There are two instances: one with
// READ_LATENCY = 2 and one with READ_LATENCY = 0. Both share the clock,
// reset and preload write port, so they hold the same program image, but
// each has its own request inputs. Every expected value below is
// hand-computed from the line/word layout and the latency rule
// (response READ_LATENCY + 4 edges after the accepting edge).
// ---------------------------------------------------------------------------
module tb_i_mem_fill_rsp;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [31:0]  wr_addr;
  logic [31:0]  wr_data;

  logic         req_valid;
  logic [31:0]  req_addr;
  logic         rsp_valid;
  logic [31:0]  rsp_address;
  logic [127:0] rsp_line;
  logic         busy;
  logic         drop_err;

  logic         z_req_valid;
  logic [31:0]  z_req_addr;
  logic         z_rsp_valid;
  logic [31:0]  z_rsp_address;
  logic [127:0] z_rsp_line;
  logic         z_busy;
  logic         z_drop_err;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] LINE_A = 128'hA0000004_A0000003_A0000002_A0000001;
  localparam logic [127:0] LINE_B = 128'hB0000004_B0000003_B0000002_B0000001;
  localparam logic [127:0] LINE_C = 128'hC0000004_C0000003_C0000002_C0000001;
  localparam logic [127:0] LINE_C_NEW = 128'hC0000004_C0000003_DEADBEEF_C0000001;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  i_mem_fill_rsp #(.MEM_DEPTH(1024), .READ_LATENCY(2)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .fill_requested_address_valid (req_valid),
    .fill_requested_address       (req_addr),
    .rsp_valid                    (rsp_valid),
    .rsp_address                  (rsp_address),
    .rsp_filled_instruction       (rsp_line),
    .busy                         (busy),
    .drop_err                     (drop_err),
    .wr_en                        (wr_en),
    .wr_addr                      (wr_addr),
    .wr_data                      (wr_data)
  );

  i_mem_fill_rsp #(.MEM_DEPTH(1024), .READ_LATENCY(0)) dut_z (
    .clk                          (clk),
    .rst                          (rst),
    .fill_requested_address_valid (z_req_valid),
    .fill_requested_address       (z_req_addr),
    .rsp_valid                    (z_rsp_valid),
    .rsp_address                  (z_rsp_address),
    .rsp_filled_instruction       (z_rsp_line),
    .busy                         (z_busy),
    .drop_err                     (z_drop_err),
    .wr_en                        (wr_en),
    .wr_addr                      (wr_addr),
    .wr_data                      (wr_data)
  );

  // Advance one edge and settle 1 ns past it so that inputs change and
  // outputs are sampled away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wide comparison (addresses and lines are widened to 128 bits).
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Single-bit comparison.
  task automatic checkFlag(input string tag, input logic observed,
                           input logic expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drive the request pins of the latency-2 instance.
  task automatic applyStimulus(input logic v, input logic [31:0] a);
    req_valid = v;
    req_addr  = a;
  endtask

  // One preload write, landing on the next edge.
  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Full fill on the latency-2 instance: accept at E0, silent through E0+5,
  // response after E0+6, gone again after E0+7 with data held.
  task automatic fillLine(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_addr, input logic [127:0] exp_line);
    applyStimulus(1'b1, addr);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkFlag({tag, " busy_after_accept"}, busy, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkFlag({tag, " no_early_rsp"}, rsp_valid, 1'b0);
    end
    tick();
    checkFlag({tag, " rsp_valid"}, rsp_valid, 1'b1);
    checkOutput({tag, " rsp_address"}, 128'(rsp_address), 128'(exp_addr));
    checkOutput({tag, " rsp_line"}, rsp_line, exp_line);
    tick();
    checkFlag({tag, " rsp_one_cycle"}, rsp_valid, 1'b0);
    checkFlag({tag, " idle_after"}, busy, 1'b0);
    checkOutput({tag, " line_hold"}, rsp_line, exp_line);
  endtask

  // Safety net so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    // Reset with requests pending on both instances.
    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_addr     = 32'h0;
    wr_data     = 32'h0;
    applyStimulus(1'b1, 32'h18);
    z_req_valid = 1'b1;
    z_req_addr  = 32'h18;
    tick();
    tick();
    checkFlag("reset rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset rsp_address", 128'(rsp_address), 128'(32'h0));
    checkOutput("reset rsp_line", rsp_line, 128'h0);
    checkFlag("reset busy", busy, 1'b0);
    checkFlag("reset drop_err", drop_err, 1'b0);
    checkFlag("reset z_busy", z_busy, 1'b0);
    checkFlag("reset z_rsp_valid", z_rsp_valid, 1'b0);
    rst         = 1'b0;
    applyStimulus(1'b0, 32'h0);
    z_req_valid = 1'b0;
    z_req_addr  = 32'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkFlag("quiet rsp_valid", rsp_valid, 1'b0);
      checkFlag("quiet z_rsp_valid", z_rsp_valid, 1'b0);
      checkFlag("quiet busy", busy, 1'b0);
    end

    // Program image: four lines at 0x10, 0x20, 0x100, 0x200.
    for (int k = 0; k < 4; k++) begin
      preload(32'h10  + 32'(4 * k), 32'hA0000001 + 32'(k));
      preload(32'h20  + 32'(4 * k), 32'hB0000001 + 32'(k));
      preload(32'h100 + 32'(4 * k), 32'hC0000001 + 32'(k));
      preload(32'h200 + 32'(4 * k), 32'hD0000001 + 32'(k));
    end

    // Basic fill, latency 2, request mid-line.
    fillLine("basic", 32'h18, 32'h10, LINE_A);

    // Zero latency: response after E0+4.
    z_req_valid = 1'b1;
    z_req_addr  = 32'h18;
    tick();
    z_req_valid = 1'b0;
    checkFlag("zlat busy", z_busy, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkFlag("zlat no_early_rsp", z_rsp_valid, 1'b0);
    end
    tick();
    checkFlag("zlat rsp_valid", z_rsp_valid, 1'b1);
    checkOutput("zlat rsp_address", 128'(z_rsp_address), 128'(32'h10));
    checkOutput("zlat rsp_line", z_rsp_line, LINE_A);
    tick();
    checkFlag("zlat rsp_one_cycle", z_rsp_valid, 1'b0);
    checkFlag("zlat idle", z_busy, 1'b0);

    // Second request in the first IDLE cycle after RESP.
    z_req_valid = 1'b1;
    z_req_addr  = 32'h24;
    tick();
    z_req_valid = 1'b0;
    checkFlag("b2b accepted", z_busy, 1'b1);
    checkFlag("b2b no_drop", z_drop_err, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkFlag("b2b no_early_rsp", z_rsp_valid, 1'b0);
    end
    tick();
    checkFlag("b2b rsp_valid", z_rsp_valid, 1'b1);
    checkOutput("b2b rsp_address", 128'(z_rsp_address), 128'(32'h20));
    checkOutput("b2b rsp_line", z_rsp_line, LINE_B);
    tick();
    checkFlag("b2b rsp_one_cycle", z_rsp_valid, 1'b0);

    // Aliasing: 0x1020 maps onto word index of 0x20.
    fillLine("alias", 32'h1020, 32'h1020, LINE_B);

    // Request while busy: 0x200 at E0+2 is dropped.
    applyStimulus(1'b1, 32'h100);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkFlag("drop pre_flag", drop_err, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkFlag("drop flag_set", drop_err, 1'b1);
    for (int i = 3; i <= 5; i++) begin
      tick();
      checkFlag("drop no_early_rsp", rsp_valid, 1'b0);
    end
    tick();
    checkFlag("drop rsp_valid", rsp_valid, 1'b1);
    checkOutput("drop rsp_address", 128'(rsp_address), 128'(32'h100));
    checkOutput("drop rsp_line", rsp_line, LINE_C);
    tick();
    checkFlag("drop single_rsp", rsp_valid, 1'b0);
    checkFlag("drop idle", busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkFlag("drop no_second_rsp", rsp_valid, 1'b0);
    end
    checkFlag("drop sticky", drop_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkFlag("drop cleared_by_rst", drop_err, 1'b0);

    // Collision: write 0x104 on the beat-1 read edge (E0+4).
    applyStimulus(1'b1, 32'h100);
    tick();
    applyStimulus(1'b0, 32'h0);
    tick();
    tick();
    tick();
    wr_en   = 1'b1;
    wr_addr = 32'h104;
    wr_data = 32'hDEADBEEF;
    tick();
    wr_en   = 1'b0;
    tick();
    tick();
    checkFlag("collide rsp_valid", rsp_valid, 1'b1);
    checkOutput("collide old_word", rsp_line, LINE_C);
    tick();
    checkFlag("collide idle", busy, 1'b0);
    fillLine("collide_refill", 32'h10C, 32'h100, LINE_C_NEW);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
